mux_registrado: RTL

- Parametrised N-input, W-bit multiplexer with a registered output. Next generation of the datapath 4:1 select muxes.
- Adds load-enable capture, an auto-scan mode with a wrapping pointer, a one-cycle valid strobe and out-of-range select detection.
- Sits between register-file/ALU sources and pipeline registers wherever a held or sequenced selection is needed.

---
 rtl/mux_registrado_if.sv | 40 ++++
 rtl/mux_registrado.sv | 92 +++++++++
 2 files changed

// File: rtl/mux_registrado_if.sv
// mux_registrado_if
// Bus bundle for the registered selection mux: packed data inputs, select and
// load controls going in, registered selection results coming out.
// Optional parity output present only when MUX_REG_PARIDADE_EN is defined.
interface mux_registrado_if #(
  parameter int LARGURA      = 32,
  parameter int NUM_ENTRADAS = 4,
  parameter int SEL_W        = 2
);
  logic [NUM_ENTRADAS*LARGURA-1:0] entradas;
  logic [SEL_W-1:0]                controle;
  logic                            carrega;
  logic                            modo;
  logic                            limpa;
  logic [LARGURA-1:0]              saida;
  logic [SEL_W-1:0]                sel_atual;
  logic                            valido;
  logic                            erro_sel;
`ifdef MUX_REG_PARIDADE_EN
  logic                            paridade;
`endif

  // Source side: drives data and controls, observes the registered result.
  modport master (
    output entradas, controle, carrega, modo, limpa,
    input  saida, sel_atual, valido, erro_sel
`ifdef MUX_REG_PARIDADE_EN
    , input paridade
`endif
  );

  // Mux side: consumes data and controls, produces the registered result.
  modport slave (
    input  entradas, controle, carrega, modo, limpa,
    output saida, sel_atual, valido, erro_sel
`ifdef MUX_REG_PARIDADE_EN
    , output paridade
`endif
  );
endinterface

// File: rtl/mux_registrado.sv
// mux_registrado
// N-input, W-bit multiplexer with registered output. A load (carrega) captures
// either the input chosen by controle (modo=0) or the input addressed by an
// internal wrapping scan pointer (modo=1). valido pulses the cycle after every
// load; erro_sel pulses after a direct load whose index has no input behind it.
// Optional feature macro: MUX_REG_PARIDADE_EN adds a registered parity output.
module mux_registrado #(
  parameter int LARGURA      = 32,
  parameter int NUM_ENTRADAS = 4,
  parameter int SEL_W        = 2
) (
  input logic           clock,
  input logic           reset,
  mux_registrado_if.slave bus
);

  if (NUM_ENTRADAS < 2 || NUM_ENTRADAS > 16) begin : g_chk_n
    $error("mux_registrado: NUM_ENTRADAS must be in 2..16");
  end
  if (SEL_W != $clog2(NUM_ENTRADAS)) begin : g_chk_sel
    $error("mux_registrado: SEL_W must equal ceil(log2(NUM_ENTRADAS))");
  end

  localparam logic [SEL_W:0]   LIMITE = (SEL_W+1)'(NUM_ENTRADAS);
  localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(NUM_ENTRADAS-1);

  logic [LARGURA-1:0] vet [NUM_ENTRADAS];
  logic [SEL_W-1:0]   ponteiro;
  logic [SEL_W-1:0]   idx_scan;
  logic [SEL_W-1:0]   idx;
  logic               no_intervalo;
  logic [LARGURA-1:0] dado;

  for (genvar k = 0; k < NUM_ENTRADAS; k++) begin : g_vet
    assign vet[k] = bus.entradas[k*LARGURA +: LARGURA];
  end

  // Successor index with wrap at the last real input.
  function automatic logic [SEL_W-1:0] proximo(input logic [SEL_W-1:0] atual);
    return (atual == ULTIMO) ? '0 : atual + SEL_W'(1);
  endfunction

  // A clear coinciding with a scan load restarts the scan at input 0.
  assign idx_scan     = bus.limpa ? '0 : ponteiro;
  assign idx          = bus.modo ? idx_scan : bus.controle;
  assign no_intervalo = ({1'b0, bus.controle} < LIMITE);

  // Single shared data mux; an index with no input behind it yields zero.
  always_comb begin
    dado = '0;
    for (int k = 0; k < NUM_ENTRADAS; k++) begin
      if (idx == SEL_W'(k)) dado = vet[k];
    end
  end

  // Capture register, strobes and scan pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.saida     <= '0;
      bus.sel_atual <= '0;
      bus.valido    <= 1'b0;
      bus.erro_sel  <= 1'b0;
      ponteiro      <= '0;
    end else begin
      bus.valido   <= bus.carrega;
      bus.erro_sel <= bus.carrega & ~bus.modo & ~no_intervalo;
      if (bus.carrega) begin
        bus.saida     <= dado;
        bus.sel_atual <= idx;
        if (bus.modo) begin
          ponteiro <= proximo(idx_scan);
        end else if (no_intervalo) begin
          ponteiro <= proximo(bus.controle);
        end
      end else if (bus.limpa) begin
        ponteiro <= '0;
      end
    end
  end

`ifdef MUX_REG_PARIDADE_EN
  // Parity of the captured word, zero when the load had no valid source.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.paridade <= 1'b0;
    end else if (bus.carrega) begin
      bus.paridade <= ^dado;
    end
  end
`endif

endmodule
